dmem_responder: RTL and testbench

- Data-memory responder for the core's load/store port: `wr`, `rd`, `addr[8:0]`, `wr_data`, `rd_data`.
- Adds `funct3`-sized, little-endian byte/half/word access with sign/zero extension.
- Has a configurable wait-state FSM that stalls the core while an access is in flight.
- Flags misaligned and illegal accesses.
- Sits beside the core at top level as the slave end of the datapath memory interface.

---
 rtl/dmem_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the core's load/store port. Provides byte, half
// and word little-endian accesses with sign/zero extension of loads, a
// wait-state FSM that stalls the core for LATENCY cycles per access, and an
// error flag for misaligned or illegal requests.
//
// Optional feature macro: DMEM_MMIO_EN
//   When defined, word index 127 (byte addresses 0x1FC-0x1FF) is redirected
//   to the mmio_out register instead of the RAM array.
//
// Parameters:
//   DATA_W  - data word width (only 32 is supported)
//   DEPTH   - number of 32-bit words (<= 128)
//   LATENCY - stall cycles per access (1..15)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   rd        in   load request, held while stall=1
//   wr        in   store request, held while stall=1
//   addr      in   9-bit byte address
//   wr_data   in   right-aligned store data
//   funct3    in   000 B, 001 H, 010 W, 100 BU, 101 HU
//   rd_data   out  registered, extended load result
//   mmio_out  out  memory-mapped output register (DMEM_MMIO_EN only)
//   stall     out  combinational core stall
//   err       out  misaligned/illegal flag, high only in DONE
module dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 128,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [8:0]        addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] rd_data,
`ifdef DMEM_MMIO_EN
  output logic [DATA_W-1:0] mmio_out,
`endif
  output logic              stall,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] DEPTH_L  = 8'(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state;
  state_t            next_state;
  logic [3:0]        cnt;

  logic [8:0]        addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        funct3_q;
  logic              rd_q;
  logic              wr_q;

  logic              accept;
  logic              commit;
  logic              req_rd;
  logic              req_wr;
  logic [8:0]        req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [2:0]        req_funct3;
  logic [6:0]        req_idx;
  logic [1:0]        req_lane;
  logic              req_err;
  logic              mmio_hit;
  logic              mem_we;
  logic              mmio_we;

  logic [3:0]        lane_en;
  logic [DATA_W-1:0] bit_mask;
  logic [DATA_W-1:0] wr_shift;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] load_ext;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept = (state == IDLE) && (rd || wr);
  assign stall  = accept || (state == WAIT);

  // In IDLE the request is taken straight from the port so a single-cycle
  // access can commit on the accept edge; afterwards the latched copy is used.
  always_comb begin
    req_rd     = rd_q;
    req_wr     = wr_q;
    req_addr   = addr_q;
    req_wdata  = wdata_q;
    req_funct3 = funct3_q;
    if (state == IDLE) begin
      req_rd     = rd;
      req_wr     = wr;
      req_addr   = addr;
      req_wdata  = wr_data;
      req_funct3 = funct3;
    end
  end

  assign req_idx  = req_addr[8:2];
  assign req_lane = req_addr[1:0];

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rd || wr) begin
          next_state = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The commit edge is the one that enters DONE; suppressed while reset is
  // asserted so an access in flight is dropped without touching memory.
  assign commit = reset && (next_state == DONE);

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = req_addr[0];
      3'b010:         req_err = (req_lane != 2'b00);
      default:        req_err = 1'b1;
    endcase
    if (req_wr && req_funct3[2]) begin
      req_err = 1'b1;
    end
    if ({1'b0, req_idx} >= DEPTH_L) begin
      req_err = 1'b1;
    end
    if (req_rd && req_wr) begin
      req_err = 1'b1;
    end
  end

`ifdef DMEM_MMIO_EN
  assign mmio_hit = (req_idx == 7'd127);
  assign cur_word = mmio_hit ? mmio_out : mem[req_idx];
`else
  assign mmio_hit = 1'b0;
  assign cur_word = mem[req_idx];
`endif

  // Byte-lane enables for the store, expanded to a bit mask for merging.
  always_comb begin
    bit_mask = '0;
    case (req_funct3[1:0])
      2'b00:   lane_en = 4'b0001 << req_lane;
      2'b01:   lane_en = 4'b0011 << req_lane;
      default: lane_en = 4'b1111;
    endcase
    for (int i = 0; i < 4; i++) begin
      bit_mask[8*i +: 8] = {8{lane_en[i]}};
    end
  end

  assign wr_shift = req_wdata << {req_lane, 3'b000};
  assign merged   = (cur_word & ~bit_mask) | (wr_shift & bit_mask);
  assign rd_shift = cur_word >> {req_lane, 3'b000};

  always_comb begin
    case (req_funct3)
      3'b000:  load_ext = {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {{(DATA_W-8){1'b0}}, rd_shift[7:0]};
      3'b101:  load_ext = {{(DATA_W-16){1'b0}}, rd_shift[15:0]};
      default: load_ext = cur_word;
    endcase
  end

  assign mem_we  = commit && req_wr && !req_err && !mmio_hit;
  assign mmio_we = commit && req_wr && !req_err && mmio_hit;

  // FSM state, wait counter, request latch, load result and error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      err   <= commit && req_err;
      if (accept) begin
        addr_q   <= addr;
        wdata_q  <= wr_data;
        funct3_q <= funct3;
        rd_q     <= rd;
        wr_q     <= wr;
        cnt      <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd1)) begin
        cnt <= cnt - 4'd1;
      end
      // A rejected load (including rd&wr together) returns zero; a rejected
      // store leaves the previous load value in place.
      if (commit && req_rd) begin
        rd_data <= req_err ? '0 : load_ext;
      end
    end
  end

  // RAM array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[req_idx] <= merged;
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmio_out <= '0;
    end else if (mmio_we) begin
      mmio_out <= merged;
    end
  end
`else
  logic unused_mmio;
  assign unused_mmio = mmio_we;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Self-checking bench for dmem_responder. Two instances are exercised:
// dut_a with LATENCY=1 and dut_b with LATENCY=3, each with its own reset.
// Stimulus pushes the expected DONE-cycle response into a per-instance queue;
// a monitor on the falling edge detects the end of each stall window and
// compares stall length, err and rd_data against the popped entry.
// With DMEM_MMIO_EN defined the mmio_out register is also checked.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_rd, a_wr, a_stall, a_err;
  logic [8:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic [2:0]  a_f3;
  logic        b_reset, b_rd, b_wr, b_stall, b_err;
  logic [8:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [2:0]  b_f3;
`ifdef DMEM_MMIO_EN
  logic [31:0] a_mmio, b_mmio;
`endif

  dmem_responder #(.DATA_W(32), .DEPTH(128), .LATENCY(1)) dut_a (
    .clk(clk), .reset(a_reset), .rd(a_rd), .wr(a_wr), .addr(a_addr),
    .wr_data(a_wdata), .funct3(a_f3), .rd_data(a_rdata),
`ifdef DMEM_MMIO_EN
    .mmio_out(a_mmio),
`endif
    .stall(a_stall), .err(a_err)
  );

  dmem_responder #(.DATA_W(32), .DEPTH(128), .LATENCY(3)) dut_b (
    .clk(clk), .reset(b_reset), .rd(b_rd), .wr(b_wr), .addr(b_addr),
    .wr_data(b_wdata), .funct3(b_f3), .rd_data(b_rdata),
`ifdef DMEM_MMIO_EN
    .mmio_out(b_mmio),
`endif
    .stall(b_stall), .err(b_err)
  );

  typedef struct {
    string       name;
    int          stall_cycles;
    logic        err;
    logic [31:0] rd_data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   fails  = 0;
  int   a_cycles = 0;
  int   b_cycles = 0;

  function automatic void check_output(input string name, input logic [31:0] act,
                                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor for dut_a: a stall window ending marks the DONE cycle.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!a_reset) begin
      a_cycles = 0;
    end else if (a_stall) begin
      a_cycles++;
      check_output("a err low while stalled", {31'b0, a_err}, 32'd0);
    end else if (a_cycles != 0) begin
      if (q_a.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL a unexpected response: got DONE, expected none");
      end else begin
        e = q_a.pop_front();
        check_output({"a ", e.name, " stall"}, a_cycles, e.stall_cycles);
        check_output({"a ", e.name, " err"}, {31'b0, a_err}, {31'b0, e.err});
        check_output({"a ", e.name, " rd_data"}, a_rdata, e.rd_data);
      end
      a_cycles = 0;
    end
  end

  // Monitor for dut_b, same scheme.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!b_reset) begin
      b_cycles = 0;
    end else if (b_stall) begin
      b_cycles++;
      check_output("b err low while stalled", {31'b0, b_err}, 32'd0);
    end else if (b_cycles != 0) begin
      if (q_b.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL b unexpected response: got DONE, expected none");
      end else begin
        e = q_b.pop_front();
        check_output({"b ", e.name, " stall"}, b_cycles, e.stall_cycles);
        check_output({"b ", e.name, " err"}, {31'b0, b_err}, {31'b0, e.err});
        check_output({"b ", e.name, " rd_data"}, b_rdata, e.rd_data);
      end
      b_cycles = 0;
    end
  end

  task automatic drive(input bit on_b, input logic r, input logic w, input logic [8:0] ad,
                       input logic [31:0] wd, input logic [2:0] f3);
    if (on_b) begin
      b_rd = r; b_wr = w; b_addr = ad; b_wdata = wd; b_f3 = f3;
    end else begin
      a_rd = r; a_wr = w; a_addr = ad; a_wdata = wd; a_f3 = f3;
    end
  endtask

  // Issue one access, hold it until stall drops (DONE), release on the
  // edge leaving DONE. Call just after a rising edge.
  task automatic apply_stimulus(input bit on_b, input string name, input logic r,
                                input logic w, input logic [8:0] ad, input logic [31:0] wd,
                                input logic [2:0] f3, input logic exp_err,
                                input logic [31:0] exp_rd);
    exp_t e;
    int   waited;
    logic st;
    e.name = name;
    e.stall_cycles = on_b ? 3 : 1;
    e.err = exp_err;
    e.rd_data = exp_rd;
    if (on_b) q_b.push_back(e);
    else q_a.push_back(e);
    drive(on_b, r, w, ad, wd, f3);
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
      st = on_b ? b_stall : a_stall;
    end while (st && waited < 40);
    if (st) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s timeout: stall still 1 after %0d cycles, expected 0", name, waited);
    end
    @(posedge clk);
    #1;
    drive(on_b, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    a_reset = 1'b0;
    b_reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
    drive(1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check_output("a reset rd_data", a_rdata, 32'h0);
    check_output("a reset err", {31'b0, a_err}, 32'd0);
    check_output("a reset stall", {31'b0, a_stall}, 32'd0);
    check_output("b reset rd_data", b_rdata, 32'h0);
`ifdef DMEM_MMIO_EN
    check_output("a reset mmio_out", a_mmio, 32'h0);
`endif
    a_reset = 1'b1;
    b_reset = 1'b1;
    @(posedge clk);
    #1;

    // LATENCY=1 instance
    apply_stimulus(0, "SW 010", 0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 0, 32'h00000000);
    apply_stimulus(0, "LW 010", 1, 0, 9'h010, 32'h0, 3'b010, 0, 32'hDEADBEEF);
    apply_stimulus(0, "LB 013", 1, 0, 9'h013, 32'h0, 3'b000, 0, 32'hFFFFFFDE);
    apply_stimulus(0, "LBU 013", 1, 0, 9'h013, 32'h0, 3'b100, 0, 32'h000000DE);
    apply_stimulus(0, "LH 012", 1, 0, 9'h012, 32'h0, 3'b001, 0, 32'hFFFFDEAD);
    apply_stimulus(0, "LHU 012", 1, 0, 9'h012, 32'h0, 3'b101, 0, 32'h0000DEAD);
    apply_stimulus(0, "SB 011", 0, 1, 9'h011, 32'h00000011, 3'b000, 0, 32'h0000DEAD);
    apply_stimulus(0, "LW 010 after SB", 1, 0, 9'h010, 32'h0, 3'b010, 0, 32'hDEAD11EF);
    apply_stimulus(0, "LW 012 misaligned", 1, 0, 9'h012, 32'h0, 3'b010, 1, 32'h00000000);
    apply_stimulus(0, "SH 011 misaligned", 0, 1, 9'h011, 32'h00005555, 3'b001, 1, 32'h00000000);
    apply_stimulus(0, "LW 010 after bad SH", 1, 0, 9'h010, 32'h0, 3'b010, 0, 32'hDEAD11EF);
    apply_stimulus(0, "rd+wr 010", 1, 1, 9'h010, 32'hFFFFFFFF, 3'b010, 1, 32'h00000000);
    apply_stimulus(0, "LW 010 after rd+wr", 1, 0, 9'h010, 32'h0, 3'b010, 0, 32'hDEAD11EF);
    apply_stimulus(0, "load f3=011", 1, 0, 9'h010, 32'h0, 3'b011, 1, 32'h00000000);
    apply_stimulus(0, "store f3=100", 0, 1, 9'h010, 32'h00000022, 3'b100, 1, 32'h00000000);
    apply_stimulus(0, "store f3=111", 0, 1, 9'h010, 32'h00000033, 3'b111, 1, 32'h00000000);
    apply_stimulus(0, "LW 010 after bad stores", 1, 0, 9'h010, 32'h0, 3'b010, 0, 32'hDEAD11EF);
    apply_stimulus(0, "SB 014", 0, 1, 9'h014, 32'hFFFFFF7F, 3'b000, 0, 32'hDEAD11EF);
    apply_stimulus(0, "LB 014 positive", 1, 0, 9'h014, 32'h0, 3'b000, 0, 32'h0000007F);
    apply_stimulus(0, "SH 016", 0, 1, 9'h016, 32'hFFFF8001, 3'b001, 0, 32'h0000007F);
    apply_stimulus(0, "LH 016", 1, 0, 9'h016, 32'h0, 3'b001, 0, 32'hFFFF8001);
    apply_stimulus(0, "LHU 016", 1, 0, 9'h016, 32'h0, 3'b101, 0, 32'h00008001);
    apply_stimulus(0, "LH 011 misaligned", 1, 0, 9'h011, 32'h0, 3'b001, 1, 32'h00000000);
    apply_stimulus(0, "SW 100", 0, 1, 9'h100, 32'h01234567, 3'b010, 0, 32'h00000000);
    apply_stimulus(0, "LW 100", 1, 0, 9'h100, 32'h0, 3'b010, 0, 32'h01234567);
`ifdef DMEM_MMIO_EN
    apply_stimulus(0, "SW 1FC mmio", 0, 1, 9'h1FC, 32'h12345678, 3'b010, 0, 32'h01234567);
    check_output("mmio after SW", a_mmio, 32'h12345678);
    apply_stimulus(0, "SB 1FD mmio", 0, 1, 9'h1FD, 32'h000000AA, 3'b000, 0, 32'h01234567);
    check_output("mmio after SB", a_mmio, 32'h1234AA78);
    apply_stimulus(0, "LHU 1FE mmio", 1, 0, 9'h1FE, 32'h0, 3'b101, 0, 32'h00001234);
`else
    apply_stimulus(0, "SW 1FC ram", 0, 1, 9'h1FC, 32'hCAFEF00D, 3'b010, 0, 32'h01234567);
    apply_stimulus(0, "LW 1FC ram", 1, 0, 9'h1FC, 32'h0, 3'b010, 0, 32'hCAFEF00D);
`endif

    // LATENCY=3 instance
    apply_stimulus(1, "SW 010", 0, 1, 9'h010, 32'hDEAD11EF, 3'b010, 0, 32'h00000000);
    apply_stimulus(1, "LW 010", 1, 0, 9'h010, 32'h0, 3'b010, 0, 32'hDEAD11EF);
    apply_stimulus(1, "LW 012 misaligned", 1, 0, 9'h012, 32'h0, 3'b010, 1, 32'h00000000);
    apply_stimulus(1, "LW 010 again", 1, 0, 9'h010, 32'h0, 3'b010, 0, 32'hDEAD11EF);

    // Store aborted by reset while in WAIT
    drive(1'b1, 1'b0, 1'b1, 9'h010, 32'h00000000, 3'b010);
    @(posedge clk);
    #1;
    check_output("b abort stall in WAIT", {31'b0, b_stall}, 32'd1);
    @(posedge clk);
    #1;
    b_reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
    #5;
    check_output("b abort stall in reset", {31'b0, b_stall}, 32'd0);
    check_output("b abort rd_data in reset", b_rdata, 32'h0);
    b_reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("b abort stall after reset", {31'b0, b_stall}, 32'd0);
    apply_stimulus(1, "LW 010 after abort", 1, 0, 9'h010, 32'h0, 3'b010, 0, 32'hDEAD11EF);

    repeat (2) @(posedge clk);
    #1;
    check_output("a scoreboard drained", q_a.size(), 32'd0);
    check_output("b scoreboard drained", q_b.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
